// File: rtl/core_if_ibuf_pkg.sv
// ============================================================================
// core_if_ibuf_pkg : types and constants for the fetch instruction buffer
// Revision 1.0
// ============================================================================
`default_nettype none

// Fallback values, used only when core_defines.v is not earlier in the file list
`ifndef CORE_DEFINES_V
`define CORE_DEFINES_V
`define CORE_XLEN        32
`define CORE_INST_WIDTH  32
`define CORE_IBUF_DEPTH  4
`define CORE_NOP_INST    32'h00000013
`endif

package core_if_ibuf_pkg;

  localparam int XLEN   = `CORE_XLEN;
  localparam int INST_W = `CORE_INST_WIDTH;
  localparam logic [INST_W-1:0] NOP_INST = `CORE_NOP_INST;

  typedef struct packed {
    logic              err;
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ibuf_entry_t;

  // Value presented to decode when nothing is buffered
  function automatic ibuf_entry_t empty_entry();
    ibuf_entry_t e;
    e.err  = 1'b0;
    e.pc   = '0;
    e.inst = NOP_INST;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_defines.v
// Shared core-wide width and constant defines.
`ifndef CORE_DEFINES_V
`define CORE_DEFINES_V
`define CORE_XLEN        32
`define CORE_INST_WIDTH  32
`define CORE_IBUF_DEPTH  4
`define CORE_NOP_INST    32'h00000013
`endif

// File: rtl/core_ibuf_mem.sv
// ============================================================================
// core_ibuf_mem : DEPTH x {err, pc, inst} storage, 1 write port, 1 async read
// Revision 1.0
// ============================================================================
`default_nettype none

module core_ibuf_mem
  import core_if_ibuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  ibuf_entry_t              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output ibuf_entry_t              o_rdata
);

  // No reset: contents are never observed while the buffer is empty
  ibuf_entry_t mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

`default_nettype wire

// File: rtl/core_if_ibuf.sv
// ============================================================================
// core_if_ibuf : fetch-to-decode instruction buffer (FIFO, flushable)
// Optional same-cycle bypass when empty: CORE_IBUF_BYPASS_EN. Revision 1.0
// ============================================================================
`default_nettype none

module core_if_ibuf
  import core_if_ibuf_pkg::*;
#(
  parameter int DEPTH = `CORE_IBUF_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_ifu_valid,
  output logic                   o_ifu_ready,
  input  logic [INST_W-1:0]      i_ifu_inst,
  input  logic [XLEN-1:0]        i_ifu_pc,
  input  logic                   i_ifu_err,
  output logic                   o_id_valid,
  input  logic                   i_id_ready,
  output logic [INST_W-1:0]      o_id_inst,
  output logic [XLEN-1:0]        o_id_pc,
  output logic                   o_id_err,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        w_empty;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  ibuf_entry_t w_wdata;
  ibuf_entry_t w_rdata;
  ibuf_entry_t w_head;

  assign w_wdata.err  = i_ifu_err;
  assign w_wdata.pc   = i_ifu_pc;
  assign w_wdata.inst = i_ifu_inst;

  assign w_empty     = (count_q == '0);
  // Ready depends on registered occupancy only, so a pop never frees a slot early
  assign o_ifu_ready = (count_q < FULL_COUNT);
  assign o_count     = count_q;

`ifdef CORE_IBUF_BYPASS_EN
  assign w_bypass = w_empty & i_ifu_valid & ~i_flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop  = ~w_empty & i_id_ready & ~i_flush;
  // A bypassed entry that decode takes immediately is never written
  assign w_push = i_ifu_valid & o_ifu_ready & ~i_flush & ~(w_bypass & i_id_ready);

  assign o_id_valid = ~i_flush & (~w_empty | w_bypass);

  always_comb begin
    w_head = empty_entry();
    if (w_bypass) begin
      w_head = w_wdata;
    end else if (!w_empty) begin
      w_head = w_rdata;
    end
  end

  assign o_id_inst = w_head.inst;
  assign o_id_pc   = w_head.pc;
  assign o_id_err  = w_head.err;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  core_ibuf_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (wr_ptr_q),
    .i_wdata (w_wdata),
    .i_raddr (rd_ptr_q),
    .o_rdata (w_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_core_if_ibuf.sv
// ============================================================================
// tb_core_if_ibuf : directed self-checking bench for core_if_ibuf (DEPTH=4)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_core_if_ibuf;
  import core_if_ibuf_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              ifu_valid;
  logic              ifu_ready;
  logic [INST_W-1:0] ifu_inst;
  logic [XLEN-1:0]   ifu_pc;
  logic              ifu_err;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [XLEN-1:0]   id_pc;
  logic              id_err;
  logic [2:0]        count;

  int n_total = 0;
  int n_bad   = 0;

  core_if_ibuf #(.DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_ifu_valid (ifu_valid),
    .o_ifu_ready (ifu_ready),
    .i_ifu_inst  (ifu_inst),
    .i_ifu_pc    (ifu_pc),
    .i_ifu_err   (ifu_err),
    .o_id_valid  (id_valid),
    .i_id_ready  (id_ready),
    .o_id_inst   (id_inst),
    .o_id_pc     (id_pc),
    .o_id_err    (id_err),
    .o_count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc + 32'h1000_0013;
  endfunction

  // Apply inputs just after a falling edge; outputs are then sampled mid-low-phase
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic err, input logic rdy, input logic fl);
    @(negedge clk);
    ifu_valid = v;
    ifu_pc    = pc;
    ifu_inst  = inst;
    ifu_err   = err;
    id_ready  = rdy;
    flush     = fl;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; ifu_valid = 1'b0; ifu_inst = '0;
    ifu_pc = '0; ifu_err = 1'b0; id_ready = 1'b0;

    // Asynchronous reset, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_ifu_ready", 64'(ifu_ready), 64'd1);
    check("rst_id_inst", 64'(id_inst), 64'h13);
    check("rst_id_pc", 64'(id_pc), 64'd0);
    check("rst_id_err", 64'(id_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push, latency one (or zero with bypass)
    drive(1'b1, 32'h8000_0000, 32'h0050_0093, 1'b0, 1'b1, 1'b0);
`ifdef CORE_IBUF_BYPASS_EN
    check("first_bypass_valid", 64'(id_valid), 64'd1);
    check("first_bypass_inst", 64'(id_inst), 64'h0050_0093);
    idle(1'b1);
    check("first_bypass_count", 64'(count), 64'd0);
`else
    check("first_same_cycle_valid", 64'(id_valid), 64'd0);
    idle(1'b1);
    check("first_valid", 64'(id_valid), 64'd1);
    check("first_inst", 64'(id_inst), 64'h0050_0093);
    check("first_pc", 64'(id_pc), 64'h8000_0000);
    check("first_count", 64'(count), 64'd1);
`endif
    idle(1'b1);
    check("first_drained_valid", 64'(id_valid), 64'd0);
    check("first_drained_inst", 64'(id_inst), 64'h13);
    check("first_drained_count", 64'(count), 64'd0);

    // Fill to full with decode stalled; fifth offer is refused
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(4 * i), inst_of(32'(4 * i)), 1'b0, 1'b0, 1'b0);
      if (i == 2) begin
        check("stall_pc_stable", 64'(id_pc), 64'h0);
        check("stall_inst_stable", 64'(id_inst), 64'(inst_of(32'h0)));
      end
    end
    check("full_ifu_ready", 64'(ifu_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    // Pop while full: slot becomes usable only next cycle
    drive(1'b1, 32'h10, inst_of(32'h10), 1'b0, 1'b1, 1'b0);
    check("full_pop_ready", 64'(ifu_ready), 64'd0);
    check("order_pc0", 64'(id_pc), 64'h0);
    for (int k = 1; k < 4; k++) begin
      idle(1'b1);
      check("order_valid", 64'(id_valid), 64'd1);
      check("order_pc", 64'(id_pc), 64'(4 * k));
      if (k == 1) begin
        check("after_full_count", 64'(count), 64'd3);
        check("after_full_ready", 64'(ifu_ready), 64'd1);
      end
    end
    idle(1'b0);
    check("full_drained_valid", 64'(id_valid), 64'd0);
    check("full_drained_count", 64'(count), 64'd0);

    // Steady state at count=2: push and pop every cycle, pointers wrap
    drive(1'b1, 32'h200, inst_of(32'h200), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h204, inst_of(32'h204), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'(32'h208 + 4 * k), inst_of(32'(32'h208 + 4 * k)), 1'b0, 1'b1, 1'b0);
      check("stream_count", 64'(count), 64'd2);
      check("stream_pc", 64'(id_pc), 64'(32'h200 + 4 * k));
    end
    idle(1'b1);
    check("stream_tail_pc0", 64'(id_pc), 64'h228);
    check("stream_tail_inst0", 64'(id_inst), 64'(inst_of(32'h228)));
    idle(1'b1);
    check("stream_tail_pc1", 64'(id_pc), 64'h22C);
    idle(1'b0);
    check("stream_drained_count", 64'(count), 64'd0);

    // Flush with three buffered and one incoming
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'(32'h300 + 4 * i), inst_of(32'(32'h300 + 4 * i)), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h30C, inst_of(32'h30C), 1'b0, 1'b1, 1'b1);
    check("flush_pre_count", 64'(count), 64'd3);
    check("flush_id_valid", 64'(id_valid), 64'd0);
    idle(1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_after_valid", 64'(id_valid), 64'd0);
    check("flush_after_inst", 64'(id_inst), 64'h13);
    drive(1'b1, 32'h400, inst_of(32'h400), 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    check("post_flush_pc", 64'(id_pc), 64'h400);
    check("post_flush_count", 64'(count), 64'd1);
    idle(1'b0);

    // Error flag travels with its own entry only
    drive(1'b1, 32'h100, inst_of(32'h100), 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h104, inst_of(32'h104), 1'b0, 1'b1, 1'b0);
    check("err_set", 64'(id_err), 64'd1);
    check("err_pc", 64'(id_pc), 64'h100);
    idle(1'b1);
    check("err_cleared", 64'(id_err), 64'd0);
    check("err_next_pc", 64'(id_pc), 64'h104);
    idle(1'b0);

    // Empty-buffer push: bypass or one-cycle latency
    drive(1'b1, 32'h500, inst_of(32'h500), 1'b0, 1'b1, 1'b0);
`ifdef CORE_IBUF_BYPASS_EN
    check("byp_valid", 64'(id_valid), 64'd1);
    check("byp_pc", 64'(id_pc), 64'h500);
    idle(1'b1);
    check("byp_count", 64'(count), 64'd0);
    check("byp_after_valid", 64'(id_valid), 64'd0);
`else
    check("nobyp_valid", 64'(id_valid), 64'd0);
    idle(1'b1);
    check("nobyp_next_valid", 64'(id_valid), 64'd1);
    check("nobyp_next_pc", 64'(id_pc), 64'h500);
    check("nobyp_next_count", 64'(count), 64'd1);
    idle(1'b0);
`endif

    // Reset mid-operation discards entries immediately
    drive(1'b1, 32'h600, inst_of(32'h600), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h604, inst_of(32'h604), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_valid", 64'(id_valid), 64'd0);
    check("midrst_ready", 64'(ifu_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h700, inst_of(32'h700), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("postrst_pc", 64'(id_pc), 64'h700);
    check("postrst_count", 64'(count), 64'd1);
    idle(1'b1);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_if_ibuf.md
CORE_IF_IBUF -- requirements
Module: core_if_ibuf

Interface
REQ-001 SHALL provide parameter DEPTH: default 4; number of buffered fetch entries; power of two, >= 2.
REQ-002 SHALL provide i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide i_flush  input  1  discard all buffered and incoming entries (redirect from branch/jump/trap).
REQ-005 SHALL provide i_ifu_valid  input  1  fetch unit presents an instruction.
REQ-006 SHALL provide o_ifu_ready  output  1  buffer can accept an instruction this cycle.
REQ-007 SHALL provide i_ifu_inst  input  `CORE_INST_WIDTH  fetched instruction word.
REQ-008 SHALL provide i_ifu_pc  input  `CORE_XLEN  PC of fetched instruction.
REQ-009 SHALL provide i_ifu_err  input  1  fetch bus error flag for this instruction.
REQ-010 SHALL provide o_id_valid  output  1  head entry presented to decode.
REQ-011 SHALL provide i_id_ready  input  1  decode consumes head entry this cycle.
REQ-012 SHALL provide o_id_inst  output  `CORE_INST_WIDTH  instruction to decode.
REQ-013 SHALL provide o_id_pc  output  `CORE_XLEN  PC of head entry.
REQ-014 SHALL provide o_id_err  output  1  fetch error flag of head entry.
REQ-015 SHALL provide o_count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Push SHALL occur iff i_ifu_valid & o_ifu_ready & !i_flush; pop SHALL occur iff o_id_valid & i_id_ready.
REQ-017 o_ifu_ready SHALL equal (o_count < DEPTH), registered-state only; no combinational path from i_id_ready.
REQ-018 Full (count==DEPTH): o_ifu_ready=0; a simultaneous pop frees a slot only from the next cycle.
REQ-019 Empty: o_id_valid=0, o_id_inst=`CORE_NOP_INST (32'h00000013), o_id_pc=0, o_id_err=0.
REQ-020 Without bypass, an entry pushed in cycle N SHALL be visible on o_id_* in cycle N+1 (latency 1).
REQ-021 Entries SHALL leave in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL leave o_count unchanged.
REQ-023 While o_id_valid & !i_id_ready, o_id_inst/pc/err SHALL remain stable.
REQ-024 i_flush SHALL combinationally force o_id_valid=0 that cycle, block push and pop, and clear pointers and count at the next edge.
REQ-025 o_count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-026 On i_rst_n low, pointers and o_count SHALL clear asynchronously: o_id_valid=0, o_ifu_ready=1, o_id_* at empty values (REQ-019).
REQ-027 Storage array SHALL NOT require reset; contents are unobservable while empty.
REQ-028 Reset asserted mid-operation SHALL discard all entries; first post-reset push behaves as on an empty buffer.

Configuration
REQ-029 Macro CORE_IBUF_BYPASS_EN defined: when empty and i_ifu_valid & !i_flush, o_id_valid=1 and o_id_* = i_ifu_* combinationally; if i_id_ready, entry is consumed without being written (count stays 0).
REQ-030 Macro CORE_IBUF_BYPASS_EN undefined: no input-to-output combinational path; REQ-020 latency applies always.

Structure
REQ-031 `CORE_IBUF_DEPTH and `CORE_NOP_INST SHALL live in the shared core_defines.v alongside the existing width defines.
REQ-032 Storage SHALL be a sub-module core_ibuf_mem (DEPTH x {err, pc, inst}, one write port, one async read port); pointer/count control stays in core_if_ibuf.

Verification
REQ-033 Reset then push 0x00500093@PC 0x80000000, i_id_ready=1 -> next cycle o_id_valid=1, inst 0x00500093, pc 0x80000000; following cycle empty, o_id_inst=0x00000013.
REQ-034 i_id_ready=0, push 5 consecutive -> 4 accepted, o_ifu_ready=0 after fourth, o_count=4; release ready -> PCs emerge in order 0x0,0x4,0x8,0xC.
REQ-035 Count=2, push and pop each cycle for 10 cycles -> o_count stays 2, pointers wrap, order preserved.
REQ-036 Count=3 with i_ifu_valid=1 and i_flush=1 -> o_id_valid=0 that cycle, o_count=0 next cycle, flushed-cycle instruction never appears.
REQ-037 Push with i_ifu_err=1 at PC 0x100 -> o_id_err=1 with o_id_pc=0x100, cleared on next entry.
REQ-038 CORE_IBUF_BYPASS_EN defined, empty, push with i_id_ready=1 -> o_id_valid=1 same cycle, o_count stays 0; undefined -> appears next cycle.
